// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
// The moore_decode helper is the single place that maps a state to its registered strobes.
package booth_pkg;

  localparam int N     = 6;
  localparam int CNT_W = 3;

  localparam logic [1:0] ADD_X = 2'b01;
  localparam logic [1:0] SUB_X = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    ADD,
    SHIFT,
    OUT_HI,
    OUT_LO
  } state_e;

  typedef struct packed {
    logic ldX;
    logic ldY;
    logic initA;
    logic initYminusOne;
    logic shRA;
    logic shRY;
    logic ldYminusOne;
    logic selL;
    logic selR;
    logic busy;
    logic done;
  } strobes_t;

  // ldA/aBarS are not here: they depend on Y0Yminus1 and are decoded combinationally.
  function automatic strobes_t moore_decode(input state_e s);
    strobes_t o;
    o      = '0;
    o.busy = (s != IDLE);
    case (s)
      LOAD_X: o.ldX = 1'b1;
      LOAD_Y: begin
        o.ldY           = 1'b1;
        o.initA         = 1'b1;
        o.initYminusOne = 1'b1;
      end
      SHIFT: begin
        o.shRA        = 1'b1;
        o.shRY        = 1'b1;
        o.ldYminusOne = 1'b1;
      end
      OUT_HI: o.selL = 1'b1;
      OUT_LO: begin
        o.selR = 1'b1;
        o.done = 1'b1;
      end
      default: o.busy = (s != IDLE);
    endcase
    return o;
  endfunction

endpackage

// File: rtl/booth_iter_counter.sv
// Iteration counter for the Booth loop: clears on load, steps once per shift.
// last_o flags the final iteration (count == N-1).
module booth_iter_counter
  import booth_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign last_o = (cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/booth_controller.sv
// Control FSM for the 6-bit radix-2 Booth multiplier datapath.
// Strobes are registered alongside the state; only ldA/aBarS in ADD follow Y0Yminus1 directly.
module booth_controller
  import booth_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] Y0Yminus1,
  output logic       ldX,
  output logic       ldY,
  output logic       ldA,
  output logic       initA,
  output logic       initYminusOne,
  output logic       aBarS,
  output logic       shRA,
  output logic       shRY,
  output logic       ldYminusOne,
  output logic       selL,
  output logic       selR,
  output logic       busy,
  output logic       done
);

  state_e   state_q, state_d;
  strobes_t strb_q;
  logic     last;
  logic     cnt_clr;
  logic     cnt_inc;

  // The last shift clears the counter instead of stepping it, so it never leaves 0..N-1.
  assign cnt_clr = (state_q == LOAD_Y) || ((state_q == SHIFT) && last);
  assign cnt_inc = (state_q == SHIFT) && !last;

  booth_iter_counter u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD_X;
      LOAD_X:  state_d = LOAD_Y;
      LOAD_Y:  state_d = ADD;
      ADD:     state_d = SHIFT;
      SHIFT:   state_d = last ? OUT_HI : ADD;
      OUT_HI:  state_d = OUT_LO;
      OUT_LO:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      strb_q  <= moore_decode(state_d);
    end
  end

  assign ldA   = (state_q == ADD) && ((Y0Yminus1 == ADD_X) || (Y0Yminus1 == SUB_X));
  assign aBarS = (state_q == ADD) && (Y0Yminus1 == SUB_X);

  assign ldX           = strb_q.ldX;
  assign ldY           = strb_q.ldY;
  assign initA         = strb_q.initA;
  assign initYminusOne = strb_q.initYminusOne;
  assign shRA          = strb_q.shRA;
  assign shRY          = strb_q.shRY;
  assign ldYminusOne   = strb_q.ldYminusOne;
  assign selL          = strb_q.selL;
  assign selR          = strb_q.selR;
  assign busy          = strb_q.busy;
  assign done          = strb_q.done;

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller: a behavioural Booth datapath closes the loop, and
// products are compared against plain signed multiplication.
module tb_booth_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] yy;
  logic ldX, ldY, ldA, initA, initYminusOne, aBarS;
  logic shRA, shRY, ldYminusOne, selL, selR, busy, done;

  int n_vec = 0;
  int n_bad = 0;
  int gcyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  booth_controller dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .Y0Yminus1     (yy),
    .ldX           (ldX),
    .ldY           (ldY),
    .ldA           (ldA),
    .initA         (initA),
    .initYminusOne (initYminusOne),
    .aBarS         (aBarS),
    .shRA          (shRA),
    .shRY          (shRY),
    .ldYminusOne   (ldYminusOne),
    .selL          (selL),
    .selR          (selR),
    .busy          (busy),
    .done          (done)
  );

  // Behavioural datapath (A widened to 7 bits so A-X cannot overflow).
  logic signed [6:0] dpA = '0;
  logic        [5:0] dpX = '0, dpY = '0;
  logic              dpYm1 = 1'b0;
  logic        [5:0] opX, opY;
  logic              frc_en;
  logic        [1:0] frc_yy;
  logic signed [6:0] sx;
  logic        [5:0] outBus;

  assign sx     = {dpX[5], dpX};
  assign yy     = frc_en ? frc_yy : {dpY[0], dpYm1};
  assign outBus = selL ? dpA[5:0] : (selR ? dpY : 6'd0);

  always @(posedge clk) begin
    if (ldX) dpX <= opX;
    if (ldY) dpY <= opY;
    if (initA) dpA <= '0;
    if (initYminusOne) dpYm1 <= 1'b0;
    if (ldA) dpA <= aBarS ? dpA - sx : dpA + sx;
    if (shRA) dpA <= dpA >>> 1;
    if (shRY) dpY <= {dpA[0], dpY[5:1]};
    if (ldYminusOne) dpYm1 <= dpY[0];
  end

  typedef struct packed {
    logic ldX, ldY, ldA, initA, initY, aBarS, shRA, shRY, ldYm1, selL, selR, busy, done;
  } obs_t;

  function automatic obs_t get_obs();
    return '{ldX, ldY, ldA, initA, initYminusOne, aBarS, shRA, shRY, ldYminusOne,
             selL, selR, busy, done};
  endfunction

  // Expected strobes from the cycle map: c = cycles since start was accepted.
  function automatic obs_t exp_obs(input int c, input logic [1:0] y);
    obs_t e;
    e      = '0;
    e.busy = (c >= 1 && c <= 16);
    if (c == 1) e.ldX = 1'b1;
    else if (c == 2) begin
      e.ldY = 1'b1; e.initA = 1'b1; e.initY = 1'b1;
    end else if (c >= 3 && c <= 14 && (c % 2) == 1) begin
      e.ldA   = (y == 2'b01) || (y == 2'b10);
      e.aBarS = (y == 2'b10);
    end else if (c >= 4 && c <= 14) begin
      e.shRA = 1'b1; e.shRY = 1'b1; e.ldYm1 = 1'b1;
    end else if (c == 15) e.selL = 1'b1;
    else if (c == 16) begin
      e.selR = 1'b1; e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // One full operation starting at the next negedge (treated as cycle 0, DUT idle).
  task automatic run_op(input logic [5:0] x, input logic [5:0] y, input bit hold,
                        input bit pulses, input bit chk_prod, input string tag,
                        output logic [1:0] add3, output int c0, output int cdone);
    int         shifts;
    logic [5:0] hi, lo;
    int         p;
    logic [11:0] pe;
    shifts = 0; hi = '0; lo = '0; add3 = '0; cdone = -1;
    opX = x; opY = y;
    @(negedge clk);
    c0 = gcyc;
    chk({tag, " idle"}, 32'(get_obs()), 32'(exp_obs(0, yy)));
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = hold ? 1'b1 : (pulses && (c == 5 || c == 10));
      chk($sformatf("%s c%0d", tag, c), 32'(get_obs()), 32'(exp_obs(c, yy)));
      chk($sformatf("%s sel_excl c%0d", tag, c), 32'(selL & selR), 32'd0);
      if (shRA && shRY && ldYminusOne) shifts++;
      if (c == 3) add3 = {ldA, aBarS};
      if (c == 15) hi = outBus;
      if (c == 16) begin
        lo = outBus;
        if (done) cdone = gcyc;
      end
    end
    chk({tag, " shifts"}, 32'(shifts), 32'd6);
    if (chk_prod) begin
      p  = $signed(x) * $signed(y);
      pe = p[11:0];
      chk({tag, " product"}, 32'({hi, lo}), 32'(pe));
    end
  endtask

  typedef struct {
    logic [5:0] x, y;
    logic [5:0] hi, lo;
  } vec_t;

  typedef struct {
    logic [1:0] y;
    logic [1:0] ld_as;
  } dec_t;

  initial begin
    vec_t       tbl[8];
    dec_t       dtbl[4];
    logic [1:0] a3;
    int         c0, cd, t0, d1, d2, d3, seen_done;
    logic [5:0] hi, lo;

    tbl[0] = '{6'b000011, 6'b000101, 6'b000000, 6'b001111};  //  3 *  5 =  15
    tbl[1] = '{6'b111101, 6'b000101, 6'b111111, 6'b110001};  // -3 *  5 = -15
    tbl[2] = '{6'b100000, 6'b100000, 6'b010000, 6'b000000};  // -32*-32 = 1024
    tbl[3] = '{6'b011111, 6'b011111, 6'b001111, 6'b000001};  // 31 * 31 = 961
    tbl[4] = '{6'b100000, 6'b011111, 6'b110000, 6'b100000};  // -32*31 = -992
    tbl[5] = '{6'b111111, 6'b111111, 6'b000000, 6'b000001};  // -1 * -1 = 1
    tbl[6] = '{6'b000111, 6'b111000, 6'b111111, 6'b001000};  //  7 * -8 = -56
    tbl[7] = '{6'b000000, 6'b101010, 6'b000000, 6'b000000};  //  0 * x  = 0

    dtbl[0] = '{2'b01, 2'b10};
    dtbl[1] = '{2'b10, 2'b11};
    dtbl[2] = '{2'b11, 2'b00};
    dtbl[3] = '{2'b00, 2'b00};

    rst = 1'b1; start = 1'b0; frc_en = 1'b0; frc_yy = 2'b00; opX = '0; opY = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'(get_obs()), 32'd0);
    rst = 1'b0;

    // Controller-alone decode: Y0Yminus1 forced for whole operations.
    for (int i = 0; i < 4; i++) begin
      frc_en = 1'b1; frc_yy = dtbl[i].y;
      run_op(6'd1, 6'd1, 1'b0, 1'b0, 1'b0, $sformatf("dec%0d", i), a3, c0, cd);
      chk($sformatf("dec%0d ldA_aBarS", i), 32'(a3), 32'(dtbl[i].ld_as));
    end
    frc_en = 1'b0;

    // Table of known products: explicit hi/lo words plus the reference model.
    for (int i = 0; i < 8; i++) begin
      opX = tbl[i].x; opY = tbl[i].y;
      run_op(tbl[i].x, tbl[i].y, 1'b0, 1'b0, 1'b1, $sformatf("tbl%0d", i), a3, c0, cd);
      chk($sformatf("tbl%0d words", i), 32'({dpA[5:0], dpY}), 32'({tbl[i].hi, tbl[i].lo}));
      chk($sformatf("tbl%0d done_lat", i), 32'(cd - c0), 32'd16);
    end

    // Start pulses while busy must be ignored.
    run_op(6'b000011, 6'b000101, 1'b0, 1'b1, 1'b1, "busy_start", a3, c0, cd);
    chk("busy_start done_lat", 32'(cd - c0), 32'd16);
    @(negedge clk);
    chk("busy_start no_restart", 32'(busy), 32'd0);

    // Reset during the third SHIFT (cycle 8).
    opX = 6'b010101; opY = 6'b110011;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("rst_op c%0d", c), 32'(get_obs()), 32'(exp_obs(c, yy)));
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_op idle", 32'(get_obs()), 32'd0);
    rst = 1'b0;
    seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    chk("rst_op no_done", 32'(seen_done), 32'd0);
    run_op(6'b111101, 6'b000101, 1'b0, 1'b0, 1'b1, "post_rst", a3, c0, cd);
    chk("post_rst done_lat", 32'(cd - c0), 32'd16);

    // Back-to-back with start held high.
    run_op(6'b000011, 6'b000101, 1'b1, 1'b0, 1'b1, "b2b0", a3, t0, d1);
    run_op(6'b111101, 6'b000101, 1'b1, 1'b0, 1'b1, "b2b1", a3, c0, d2);
    run_op(6'b011111, 6'b100000, 1'b0, 1'b0, 1'b1, "b2b2", a3, c0, d3);
    chk("b2b done1", 32'(d1 - t0), 32'd16);
    chk("b2b done2", 32'(d2 - t0), 32'd33);
    chk("b2b done3", 32'(d3 - t0), 32'd50);

    // Randomised operands against signed multiplication.
    for (int i = 0; i < 40; i++) begin
      hi = 6'($urandom_range(0, 63));
      lo = 6'($urandom_range(0, 63));
      run_op(hi, lo, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
             $sformatf("rnd%0d", i), a3, c0, cd);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
